// File: rtl/hazard_fwd_tracker_if.sv
// -----------------------------------------------------------------------------
// hazard_fwd_tracker_if
// Decode-side / EX-side handshake bundle between the pipeline and the hazard
// and forwarding tracker.
//
//   master (pipeline) drives : dValid, dRs, dRt, dUseRs, dUseRt, dWreg, dRd,
//                              dIsLoad, eBrTaken
//   slave  (tracker)  drives : FwdA, FwdB (FW bits), StallN, FlushN
//                              StallCnt, FlushCnt (only with HAZARD_STATS_EN)
//
// REG_AW and MEM_STAGES must match the parameters of the tracker it connects
// to; FW is derived from MEM_STAGES exactly as in the tracker.
// Optional macro: HAZARD_STATS_EN adds the two 32-bit event counters.
// -----------------------------------------------------------------------------
interface hazard_fwd_tracker_if #(
    parameter int REG_AW     = 5,
    parameter int MEM_STAGES = 1
);
    localparam int FW = $clog2(MEM_STAGES + 2);

    logic              dValid;
    logic [REG_AW-1:0] dRs;
    logic [REG_AW-1:0] dRt;
    logic              dUseRs;
    logic              dUseRt;
    logic              dWreg;
    logic [REG_AW-1:0] dRd;
    logic              dIsLoad;
    logic              eBrTaken;
    logic [FW-1:0]     FwdA;
    logic [FW-1:0]     FwdB;
    logic              StallN;
    logic              FlushN;
`ifdef HAZARD_STATS_EN
    logic [31:0]       StallCnt;
    logic [31:0]       FlushCnt;
`endif

    modport master (
        output dValid, dRs, dRt, dUseRs, dUseRt, dWreg, dRd, dIsLoad, eBrTaken,
`ifdef HAZARD_STATS_EN
        input  StallCnt, FlushCnt,
`endif
        input  FwdA, FwdB, StallN, FlushN
    );

    modport slave (
        input  dValid, dRs, dRt, dUseRs, dUseRt, dWreg, dRd, dIsLoad, eBrTaken,
`ifdef HAZARD_STATS_EN
        output StallCnt, FlushCnt,
`endif
        output FwdA, FwdB, StallN, FlushN
    );
endinterface

// File: rtl/hazard_fwd_tracker.sv
// -----------------------------------------------------------------------------
// hazard_fwd_tracker
// Hazard / forwarding controller sitting beside the ID stage. It keeps a
// shift-register scoreboard of the writers in EX and the MEM_STAGES memory
// stages and derives operand forwarding selects, load-use stall and the
// branch flush window.
//
// Ports
//   i_clk  : clock
//   i_rst  : synchronous, active-high reset
//   bus    : hazard_fwd_tracker_if.slave
//            in  dValid, dRs, dRt, dUseRs, dUseRt, dWreg, dRd, dIsLoad, eBrTaken
//            out FwdA/FwdB (0 = regfile, k+1 = tracker entry k, 0 = EX),
//                StallN, FlushN (active low)
//
// Parameters: REG_AW, MEM_STAGES (1..4), BR_PENALTY (1..7).
// Optional macro HAZARD_STATS_EN: adds saturating StallCnt / FlushCnt.
// -----------------------------------------------------------------------------
module hazard_fwd_tracker #(
    parameter int REG_AW     = 5,
    parameter int MEM_STAGES = 1,
    parameter int BR_PENALTY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    hazard_fwd_tracker_if.slave  bus
);
    localparam int         FW        = $clog2(MEM_STAGES + 2);
    localparam int         NE        = MEM_STAGES + 1;
    localparam logic [2:0] FCNT_LOAD = 3'(BR_PENALTY - 1);

    // Scoreboard: index 0 is EX, index MEM_STAGES is the last memory stage.
    logic [NE-1:0]             r_v;
    logic [NE-1:0]             r_wreg;
    logic [NE-1:0]             r_ld;
    logic [NE-1:0][REG_AW-1:0] r_rd;
    logic [2:0]                r_fcnt;

    logic [NE-1:0]             w_live;
    logic [FW-1:0]             w_fwd_a;
    logic [FW-1:0]             w_fwd_b;
    logic                      w_stall_a;
    logic                      w_stall_b;
    logic                      w_flush;
    logic                      w_stall;
    logic                      w_accept;

    // Returns {stall, fwd} for one operand. Scanning oldest to youngest lets
    // the youngest match overwrite the result.
    function automatic logic [FW:0] resolve(
        input logic                      i_use,
        input logic [REG_AW-1:0]         i_src,
        input logic [NE-1:0]             i_live,
        input logic [NE-1:0]             i_ld,
        input logic [NE-1:0][REG_AW-1:0] i_rd
    );
        logic [FW:0] res;
        res = '0;
        for (int k = MEM_STAGES; k >= 0; k--) begin
            if (i_use && i_live[k] && (i_rd[k] == i_src)) begin
                // Load data only exists at the output of the last stage.
                if (i_ld[k] && (k < MEM_STAGES)) begin
                    res = {1'b1, {FW{1'b0}}};
                end else begin
                    res = {1'b0, FW'(k + 1)};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_live = '0;
        for (int k = 0; k < NE; k++) begin
            w_live[k] = r_v[k] & r_wreg[k] & (r_rd[k] != '0);
        end
    end

    always_comb begin
        {w_stall_a, w_fwd_a} = resolve(bus.dUseRs, bus.dRs, w_live, r_ld, r_rd);
        {w_stall_b, w_fwd_b} = resolve(bus.dUseRt, bus.dRt, w_live, r_ld, r_rd);
    end

    // A flush discards the decode instruction, so it overrides any stall.
    assign w_flush  = bus.eBrTaken | (r_fcnt != 3'd0);
    assign w_stall  = bus.dValid & (w_stall_a | w_stall_b) & ~w_flush;
    assign w_accept = bus.dValid & ~w_stall & ~w_flush & ~i_rst;

    assign bus.FlushN = i_rst | ~w_flush;
    assign bus.StallN = i_rst | ~w_stall;
    assign bus.FwdA   = (i_rst | ~bus.dValid) ? '0 : w_fwd_a;
    assign bus.FwdB   = (i_rst | ~bus.dValid) ? '0 : w_fwd_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v    <= '0;
            r_fcnt <= '0;
        end else begin
            r_v <= {r_v[NE-2:0], w_accept};
            if (bus.eBrTaken) begin
                r_fcnt <= FCNT_LOAD;
            end else if (r_fcnt != 3'd0) begin
                r_fcnt <= r_fcnt - 3'd1;
            end
        end
    end

    // Payload fields are qualified by r_v, so they need no reset.
    always_ff @(posedge i_clk) begin
        r_wreg <= {r_wreg[NE-2:0], bus.dWreg};
        r_ld   <= {r_ld[NE-2:0], bus.dIsLoad};
        r_rd   <= {r_rd[NE-2:0], bus.dRd};
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.StallCnt = r_stall_cnt;
    assign bus.FlushCnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_fwd_tracker.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_tracker
// Three trackers share one decode stream:
//   inst 0: MEM_STAGES=1 BR_PENALTY=1
//   inst 1: MEM_STAGES=2 BR_PENALTY=2
//   inst 2: MEM_STAGES=3 BR_PENALTY=2
// A model holding in-flight writers as (rd, load, age) records plus an
// absolute flush end cycle predicts every output each cycle; literal pins
// anchor the scenarios from the test plan.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_tracker;
    localparam int NI = 3;
    localparam int NS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       dValid, dUseRs, dUseRt, dWreg, dIsLoad, eBrTaken;
    logic [4:0] dRs, dRt, dRd;

    always #5 clk = ~clk;

    hazard_fwd_tracker_if #(.REG_AW(5), .MEM_STAGES(1)) bus_a ();
    hazard_fwd_tracker_if #(.REG_AW(5), .MEM_STAGES(2)) bus_b ();
    hazard_fwd_tracker_if #(.REG_AW(5), .MEM_STAGES(3)) bus_c ();

    assign bus_a.dValid = dValid;  assign bus_b.dValid = dValid;  assign bus_c.dValid = dValid;
    assign bus_a.dRs = dRs;        assign bus_b.dRs = dRs;        assign bus_c.dRs = dRs;
    assign bus_a.dRt = dRt;        assign bus_b.dRt = dRt;        assign bus_c.dRt = dRt;
    assign bus_a.dUseRs = dUseRs;  assign bus_b.dUseRs = dUseRs;  assign bus_c.dUseRs = dUseRs;
    assign bus_a.dUseRt = dUseRt;  assign bus_b.dUseRt = dUseRt;  assign bus_c.dUseRt = dUseRt;
    assign bus_a.dWreg = dWreg;    assign bus_b.dWreg = dWreg;    assign bus_c.dWreg = dWreg;
    assign bus_a.dRd = dRd;        assign bus_b.dRd = dRd;        assign bus_c.dRd = dRd;
    assign bus_a.dIsLoad = dIsLoad; assign bus_b.dIsLoad = dIsLoad; assign bus_c.dIsLoad = dIsLoad;
    assign bus_a.eBrTaken = eBrTaken; assign bus_b.eBrTaken = eBrTaken; assign bus_c.eBrTaken = eBrTaken;

    hazard_fwd_tracker #(.REG_AW(5), .MEM_STAGES(1), .BR_PENALTY(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
    hazard_fwd_tracker #(.REG_AW(5), .MEM_STAGES(2), .BR_PENALTY(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b.slave));
    hazard_fwd_tracker #(.REG_AW(5), .MEM_STAGES(3), .BR_PENALTY(2)) dut_c (
        .i_clk(clk), .i_rst(rst), .bus(bus_c.slave));

    int n_chk = 0;
    int n_err = 0;
    bit started = 1'b0;

    // ---------------- model ----------------
    int m_used [NI][NS];
    int m_rd   [NI][NS];
    int m_ld   [NI][NS];
    int m_age  [NI][NS];
    int m_flush_end [NI];
    int m_scnt [NI];
    int m_fcnt [NI];
    int cyc = 0;

    function automatic int ms_of(input int i);
        return i + 1;
    endfunction

    function automatic int bp_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic void lookup(input int i, input logic rd_en, input logic [4:0] src,
                                   output int fwd, output int stall);
        int best;
        best  = -1;
        fwd   = 0;
        stall = 0;
        for (int s = 0; s < NS; s++) begin
            if (m_used[i][s] != 0 && m_rd[i][s] != 0 && m_rd[i][s] == int'(src) &&
                (best < 0 || m_age[i][s] < m_age[i][best])) best = s;
        end
        if (rd_en && best >= 0) begin
            if (m_ld[i][best] != 0 && m_age[i][best] < ms_of(i)) stall = 1;
            else fwd = m_age[i][best] + 1;
        end
    endfunction

    function automatic void model_out(input int i, output int fa, output int fb,
                                      output int st, output int fl);
        int sa, sb;
        bit flushing;
        flushing = eBrTaken || (cyc <= m_flush_end[i]);
        lookup(i, dUseRs, dRs, fa, sa);
        lookup(i, dUseRt, dRt, fb, sb);
        if (!dValid) begin
            fa = 0; fb = 0; sa = 0; sb = 0;
        end
        st = ((sa != 0 || sb != 0) && !flushing) ? 0 : 1;
        fl = flushing ? 0 : 1;
        if (rst) begin
            fa = 0; fb = 0; st = 1; fl = 1;
        end
    endfunction

    task automatic model_clear(input int i);
        for (int s = 0; s < NS; s++) m_used[i][s] = 0;
        m_flush_end[i] = -1;
        m_scnt[i] = 0;
        m_fcnt[i] = 0;
    endtask

    always @(posedge clk) begin
        int fa, fb, st, fl;
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                model_out(i, fa, fb, st, fl);
                if (rst) begin
                    model_clear(i);
                end else begin
                    if (st == 0) m_scnt[i]++;
                    if (fl == 0) m_fcnt[i]++;
                    for (int s = 0; s < NS; s++) begin
                        if (m_used[i][s] != 0) begin
                            m_age[i][s]++;
                            if (m_age[i][s] > ms_of(i)) m_used[i][s] = 0;
                        end
                    end
                    if (dValid && dWreg && st == 1 && fl == 1) begin
                        for (int s = 0; s < NS; s++) begin
                            if (m_used[i][s] == 0) begin
                                m_used[i][s] = 1;
                                m_rd[i][s]   = int'(dRd);
                                m_ld[i][s]   = dIsLoad ? 1 : 0;
                                m_age[i][s]  = 0;
                                break;
                            end
                        end
                    end
                    if (eBrTaken) m_flush_end[i] = cyc + bp_of(i) - 1;
                end
            end
            cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int act_fa [NI];
        int act_fb [NI];
        int act_st [NI];
        int act_fl [NI];
        int fa, fb, st, fl;
        if (started) begin
            act_fa[0] = int'(bus_a.FwdA);   act_fa[1] = int'(bus_b.FwdA);   act_fa[2] = int'(bus_c.FwdA);
            act_fb[0] = int'(bus_a.FwdB);   act_fb[1] = int'(bus_b.FwdB);   act_fb[2] = int'(bus_c.FwdB);
            act_st[0] = int'(bus_a.StallN); act_st[1] = int'(bus_b.StallN); act_st[2] = int'(bus_c.StallN);
            act_fl[0] = int'(bus_a.FlushN); act_fl[1] = int'(bus_b.FlushN); act_fl[2] = int'(bus_c.FlushN);
            for (int i = 0; i < NI; i++) begin
                model_out(i, fa, fb, st, fl);
                chk("model_fwd_a", i, act_fa[i], fa);
                chk("model_fwd_b", i, act_fb[i], fb);
                chk("model_stall_n", i, act_st[i], st);
                chk("model_flush_n", i, act_fl[i], fl);
            end
`ifdef HAZARD_STATS_EN
            chk("model_stall_cnt", 0, int'(bus_a.StallCnt), m_scnt[0]);
            chk("model_stall_cnt", 1, int'(bus_b.StallCnt), m_scnt[1]);
            chk("model_stall_cnt", 2, int'(bus_c.StallCnt), m_scnt[2]);
            chk("model_flush_cnt", 0, int'(bus_a.FlushCnt), m_fcnt[0]);
            chk("model_flush_cnt", 1, int'(bus_b.FlushCnt), m_fcnt[1]);
            chk("model_flush_cnt", 2, int'(bus_c.FlushCnt), m_fcnt[2]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Applies one decode vector just after a rising edge and returns shortly
    // after the following falling edge, when outputs are settled.
    task automatic drv(input int v, input int rs, input int rt, input int urs, input int urt,
                       input int wr, input int rd, input int ld, input int br, input int r);
        @(posedge clk);
        #1;
        dValid   = (v != 0);
        dRs      = 5'(rs);
        dRt      = 5'(rt);
        dUseRs   = (urs != 0);
        dUseRt   = (urt != 0);
        dWreg    = (wr != 0);
        dRd      = 5'(rd);
        dIsLoad  = (ld != 0);
        eBrTaken = (br != 0);
        rst      = (r != 0);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; dValid = 1'b0; dRs = '0; dRt = '0; dUseRs = 1'b0; dUseRt = 1'b0;
        dWreg = 1'b0; dRd = '0; dIsLoad = 1'b0; eBrTaken = 1'b0;
        for (int i = 0; i < NI; i++) model_clear(i);
        started = 1'b1;

        // reset with hostile inputs: outputs forced idle
        drv(1, 3, 3, 1, 1, 1, 3, 1, 1, 1);
        chk("rst_stall_n", 0, int'(bus_a.StallN), 1);
        chk("rst_flush_n", 0, int'(bus_a.FlushN), 1);
        chk("rst_fwd_a", 0, int'(bus_a.FwdA), 0);
        drv(1, 3, 3, 1, 1, 1, 3, 1, 1, 1);

        // ALU forwarding from EX then MEM
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_fwd_a_ex", 0, int'(bus_a.FwdA), 1);
        chk("alu_stall_n", 0, int'(bus_a.StallN), 1);
        drv(1, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        chk("alu_fwd_b_mem", 0, int'(bus_a.FwdB), 2);
        drv(0, 3, 3, 1, 1, 0, 0, 0, 0, 0);
        chk("invalid_no_fwd", 2, int'(bus_c.FwdA), 0);
        idle(3);

        // load-use: lw r5, consumer held
        drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_stall_c1", 0, int'(bus_a.StallN), 0);
        chk("lu_fwd_a_c1", 0, int'(bus_a.FwdA), 0);
        chk("lu_stall_c1", 1, int'(bus_b.StallN), 0);
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a_c2", 0, int'(bus_a.FwdA), 2);
        chk("lu_stall_c2", 0, int'(bus_a.StallN), 1);
        chk("lu_stall_c2", 1, int'(bus_b.StallN), 0);
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a_c3", 1, int'(bus_b.FwdA), 3);
        chk("lu_stall_c3", 1, int'(bus_b.StallN), 1);
        chk("lu_stall_c3", 2, int'(bus_c.StallN), 0);
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a_c4", 2, int'(bus_c.FwdA), 4);
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(4);

        // youngest match wins; r0 writer never matches
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        drv(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("youngest_fwd_a", 0, int'(bus_a.FwdA), 1);
        chk("youngest_fwd_a", 1, int'(bus_b.FwdA), 1);
        drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("r0_fwd_a", 0, int'(bus_a.FwdA), 0);
        chk("r0_stall_n", 0, int'(bus_a.StallN), 1);
        chk("r0_stall_n", 2, int'(bus_c.StallN), 1);
        idle(4);

        // stall from operand B while operand A still forwards
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
        drv(1, 7, 6, 1, 1, 0, 0, 0, 0, 0);
        chk("mix_stall_n", 0, int'(bus_a.StallN), 0);
        chk("mix_fwd_a", 0, int'(bus_a.FwdA), 2);
        chk("mix_fwd_b", 0, int'(bus_a.FwdB), 0);
        drv(1, 7, 6, 1, 1, 0, 0, 0, 0, 0);
        drv(1, 7, 6, 1, 1, 0, 0, 0, 0, 0);
        idle(4);

        // branch taken during a load-use hazard
        drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        drv(1, 8, 0, 1, 0, 1, 9, 0, 1, 0);
        chk("br_flush_n_c1", 1, int'(bus_b.FlushN), 0);
        chk("br_stall_n_c1", 1, int'(bus_b.StallN), 1);
        chk("br_stall_n_c1", 0, int'(bus_a.StallN), 1);
        drv(1, 9, 8, 1, 1, 0, 0, 0, 0, 0);
        chk("br_flush_n_c2", 1, int'(bus_b.FlushN), 0);
        chk("br_stall_n_c2", 1, int'(bus_b.StallN), 1);
        chk("br_fwd_a_c2", 1, int'(bus_b.FwdA), 0);
        chk("br_flush_n_c2", 0, int'(bus_a.FlushN), 1);
        chk("br_fwd_b_c2", 0, int'(bus_a.FwdB), 2);
        chk("br_fwd_a_c2", 0, int'(bus_a.FwdA), 0);
        drv(1, 9, 8, 1, 1, 0, 0, 0, 0, 0);
        chk("br_flush_n_c3", 1, int'(bus_b.FlushN), 1);
        chk("br_fwd_b_c3", 1, int'(bus_b.FwdB), 3);
        chk("br_fwd_a_c3", 1, int'(bus_b.FwdA), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_reload_tail", 1, int'(bus_b.FlushN), 0);
        chk("br_reload_tail", 0, int'(bus_a.FlushN), 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_reload_done", 1, int'(bus_b.FlushN), 1);
        idle(4);

        // reset in the middle of a MEM_STAGES=3 load-use stall
        drv(1, 0, 0, 0, 0, 1, 10, 1, 0, 0);
        drv(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_stall_pre", 2, int'(bus_c.StallN), 0);
        drv(1, 10, 0, 1, 0, 0, 0, 0, 1, 1);
        chk("rst_mid_stall_n", 2, int'(bus_c.StallN), 1);
        chk("rst_mid_flush_n", 2, int'(bus_c.FlushN), 1);
        chk("rst_mid_fwd_a", 2, int'(bus_c.FwdA), 0);
        drv(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_stall_n", 2, int'(bus_c.StallN), 1);
        chk("post_rst_flush_n", 2, int'(bus_c.FlushN), 1);
        chk("post_rst_fwd_a", 2, int'(bus_c.FwdA), 0);
`ifdef HAZARD_STATS_EN
        chk("post_rst_stall_cnt", 2, int'(bus_c.StallCnt), 0);
`endif
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_tracker.md
Name: hazard_fwd_tracker

Overview:
- Parametrised hazard/forwarding controller for the pipelined CPU, replacing purely combinational compare logic.
- Keeps its own shift-register scoreboard of in-flight writers: the EX stage plus MEM_STAGES memory stages.
- Produces per-operand forwarding selects, load-use stall and branch flush, with a configurable memory latency and branch penalty.
- Sits beside the ID stage; drives pipeline-register enables and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width.
- MEM_STAGES, 1, memory pipeline stages after EX (1..4). Load data is valid only at the output of the last stage.
- BR_PENALTY, 1, flush cycles after a taken branch/jump resolves in EX (1..7).
- FW, $clog2(MEM_STAGES+2), forwarding select width (derived, not overridden).

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset; synchronous, active-high.
- dValid  in  1  decode-stage instruction valid.
- dRs, dRt  in  REG_AW  source register addresses.
- dUseRs, dUseRt  in  1  operand actually read.
- dWreg  in  1  instruction writes the register file.
- dRd  in  REG_AW  destination register.
- dIsLoad  in  1  instruction is a load.
- eBrTaken  in  1  branch/jump in EX is taken (beq&Z, bne&!Z, j, jr).
- FwdA, FwdB  out  FW  operand source: 0 = register file, k+1 = tracker entry k (0 = EX).
- StallN  out  1  active-low stall: 0 holds PC and IF/ID and inserts an EX bubble.
- FlushN  out  1  active-low flush: 0 kills the IF/ID instruction.

Behaviour:
- Tracker: entries 0..MEM_STAGES, each holding {v, wreg, rd, ld}. The entry is live when v & wreg & (rd != 0).
- Every cycle entry[k] <= entry[k-1] for k >= 1.
- entry[0] <= decode instruction if dValid & StallN & FlushN; otherwise a bubble (v = 0).
- WB is not tracked; the register file writes before it is read.
- Match for an operand: dUse & (src == entry.rd) & entry live. The youngest (lowest k) match wins.
- Forwarding: if the winning entry has ld = 0, or ld = 1 with k == MEM_STAGES, then Fwd = k+1. With no match, Fwd = 0.
- Stall: if the winning entry has ld = 1 and k < MEM_STAGES, StallN = 0 and that operand's Fwd = 0. Either operand can cause the stall.
  - A load-use stall therefore lasts MEM_STAGES-k cycles, since the bubbles advance the load.
- FwdA, FwdB and StallN are combinational from the tracker state and decode inputs; there is no added latency.
- Flush counter fcnt (3 bits):
  - eBrTaken: FlushN = 0 in the same cycle and fcnt <= BR_PENALTY-1.
  - Otherwise, when fcnt != 0: FlushN = 0 and fcnt decrements.
  - A new eBrTaken while fcnt != 0 reloads the counter.
- Flush versus stall: if FlushN = 0, StallN is forced to 1. The decode instruction is discarded and is not entered into the tracker.
- Reset: all entries v = 0, fcnt = 0.
  - While Rst is high: StallN = 1, FlushN = 1, FwdA = FwdB = 0, regardless of inputs.
  - Reset mid-stall or mid-flush aborts it on the next edge.
- dValid = 0: no stall and no forwarding requests (Fwd = 0, StallN = 1).

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds outputs StallCnt[31:0] and FlushCnt[31:0].
  - Each increments on every clock where StallN = 0 (respectively FlushN = 0) and Rst = 0.
  - Both saturate at 0xFFFFFFFF and clear on Rst.
- Not defined: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- MEM_STAGES=1: add r3 enters; next decode dRs=3 -> FwdA=1, StallN=1. Following cycle dRt=3 -> FwdB=2.
- lw r5 enters; next decode dRs=5 -> StallN=0, FwdA=0 for 1 cycle, then FwdA=2, StallN=1.
  - Repeat with MEM_STAGES=2 -> 2 stall cycles, then FwdA=3.
- r4 written in both EX and MEM entries, consumer dRs=4 -> FwdA=1 (youngest). A writer with dRd=0 -> FwdA=0, no stall.
- BR_PENALTY=2: eBrTaken while decode is a load-use consumer -> FlushN=0 for 2 cycles and StallN=1 throughout.
  - Tracker entry 0 is a bubble next cycle, so a later consumer of that rd gets Fwd=0.
- Rst asserted during a load-use stall (MEM_STAGES=3) -> next cycle StallN=1, FlushN=1, Fwd=0, all entries invalid.
  - With HAZARD_STATS_EN: StallCnt=0.
